// File: rtl/sys_bus_stream_fifo.sv
// System-bus slave that pushes written words into a FWFT FIFO drained over a valid/ready stream.
// Registers: DATA (0x0), STATUS (0x4), THRESH (0x8), CTRL (0xC); level irq when fill <= threshold.
`timescale 1ns/1ps
module sys_bus_stream_fifo #(
  parameter int AXI_DW     = 32,
  parameter int AXI_AW     = 32,
  parameter int AXI_SW     = AXI_DW/8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AXI_AW-1:0] sys_addr,
  input  logic [AXI_DW-1:0] sys_wdata,
  input  logic [AXI_SW-1:0] sys_sel,
  input  logic              sys_wen,
  input  logic              sys_ren,
  output logic [AXI_DW-1:0] sys_rdata,
  output logic              sys_ack,
  output logic              sys_err,
  output logic [AXI_DW-1:0] str_dat,
  output logic              str_vld,
  input  logic              str_rdy,
  output logic              irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_THRESH = 4'h8;
  localparam logic [3:0] OFF_CTRL   = 4'hC;

  logic [AXI_DW-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count, thresh;
  logic                  overflow, enable;
  logic                  ack_q, err_q;
  logic [AXI_DW-1:0]     rdata_q;

  logic [3:0]        off;
  logic              acc, bad, wr_ok, rd_ok;
  logic              push_req, push, pop, flush;
  logic              empty, full;
  logic [AXI_DW-1:0] rd_val;
  logic              unused;

  assign off    = sys_addr[3:0];
  assign unused = ^{sys_addr[AXI_AW-1:4], sys_wdata};

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_comb begin
    acc = sys_wen | sys_ren;
    bad = 1'b0;
    if (sys_wen & sys_ren) begin
      bad = 1'b1;
    end else if (acc) begin
      case (off)
        OFF_DATA:                      bad = sys_ren | (sys_sel != '1);
        OFF_STATUS, OFF_THRESH, OFF_CTRL: bad = 1'b0;
        default:                       bad = 1'b1;
      endcase
    end
    wr_ok    = sys_wen & ~bad;
    rd_ok    = sys_ren & ~bad;
    push_req = wr_ok & (off == OFF_DATA);
    flush    = wr_ok & (off == OFF_CTRL) & sys_wdata[1];
    // flush wins over a same-cycle pop; a pop frees the slot for a push when full
    pop      = str_vld & str_rdy & ~flush;
    push     = push_req & (~full | pop);
  end

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_STATUS: begin
        rd_val[CW-1:0] = count;
        rd_val[16]     = empty;
        rd_val[17]     = full;
        rd_val[18]     = overflow;
      end
      OFF_THRESH: rd_val[CW-1:0] = thresh;
      OFF_CTRL:   rd_val[0]      = enable;
      default:    rd_val         = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sys_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      thresh   <= '0;
      overflow <= 1'b0;
      enable   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      irq      <= 1'b1;
    end else begin
      ack_q <= acc & ~bad;
      err_q <= acc & bad;
      irq   <= (count <= thresh);
      if (rd_ok) rdata_q <= rd_val;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end

      if (push_req & full & ~pop)
        overflow <= 1'b1;
      else if (wr_ok & (off == OFF_STATUS) & sys_wdata[18])
        overflow <= 1'b0;

      if (wr_ok & (off == OFF_THRESH) & sys_sel[0]) thresh <= sys_wdata[CW-1:0];
      if (wr_ok & (off == OFF_CTRL))                enable <= sys_wdata[0];
    end
  end

  // A reset landing in the ack cycle suppresses the pending response.
  assign sys_ack   = ack_q & ~rst;
  assign sys_err   = err_q & ~rst;
  assign sys_rdata = rdata_q;
  assign str_vld   = enable & ~empty;
  assign str_dat   = mem[rd_ptr];

endmodule

// File: tb/tb_sys_bus_stream_fifo.sv
// Bench for sys_bus_stream_fifo: directed register/FIFO scenarios, then random traffic
// checked every cycle against a queue-based model of the register map and stream.
`timescale 1ns/1ps
module tb_sys_bus_stream_fifo;

  logic        clk, rst;
  logic [31:0] sys_addr, sys_wdata, sys_rdata, str_dat;
  logic [3:0]  sys_sel;
  logic        sys_wen, sys_ren, sys_ack, sys_err, str_vld, str_rdy, irq;

  sys_bus_stream_fifo dut (
    .clk(clk), .rst(rst),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
    .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(sys_rdata), .sys_ack(sys_ack), .sys_err(sys_err),
    .str_dat(str_dat), .str_vld(str_vld), .str_rdy(str_rdy), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] q[$];
  logic        m_ovf, m_en, m_irq, m_ack, m_err;
  logic [4:0]  m_thr;
  logic [31:0] m_rdata;
  logic        rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_en = 0; m_irq = 1; m_ack = 0; m_err = 0;
    m_thr = '0; m_rdata = '0;
  endtask

  // One bus cycle: drive at the falling edge, model the rising edge, check just after it.
  task automatic step(input logic w, input logic r, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    int  cnt;
    bit  bad, wok, rok, flush, pop, n_irq;
    logic [3:0]  off;
    logic [31:0] n_rd;
    sys_wen = w; sys_ren = r; sys_addr = a; sys_wdata = d; sys_sel = s; str_rdy = rdy;
    cnt = q.size();
    off = a[3:0];
    bad = 0;
    if (w && r) bad = 1;
    else if (w || r) begin
      if (off == 4'h0)                                   bad = r || (s != 4'hF);
      else if (off == 4'h4 || off == 4'h8 || off == 4'hC) bad = 0;
      else                                               bad = 1;
    end
    wok   = w && !bad;
    rok   = r && !bad;
    flush = wok && off == 4'hC && d[1];
    pop   = m_en && cnt > 0 && rdy && !flush;
    n_irq = (cnt <= int'(m_thr));
    n_rd  = m_rdata;
    if (rok) begin
      if (off == 4'h4)
        n_rd = cnt | (int'(cnt == 0) << 16) | (int'(cnt == 16) << 17) | (int'(m_ovf) << 18);
      else if (off == 4'h8) n_rd = {27'd0, m_thr};
      else                  n_rd = {31'd0, m_en};
    end

    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (wok && off == 4'h0) begin
        if (q.size() < 16) q.push_back(d);
        else m_ovf = 1;
      end
    end
    if (wok && off == 4'h4 && d[18]) m_ovf = 0;
    if (wok && off == 4'h8 && s[0])  m_thr = d[4:0];
    if (wok && off == 4'hC)          m_en = d[0];
    m_ack = (w || r) && !bad;
    m_err = (w || r) && bad;
    m_rdata = n_rd;
    m_irq = n_irq;

    #1;
    chk("ack", {31'd0, sys_ack}, {31'd0, m_ack});
    chk("err", {31'd0, sys_err}, {31'd0, m_err});
    chk("rdata", sys_rdata, m_rdata);
    chk("irq", {31'd0, irq}, {31'd0, m_irq});
    chk("vld", {31'd0, str_vld}, {31'd0, (m_en && q.size() > 0)});
    if (m_en && q.size() > 0) chk("dat", str_dat, q[0]);
    @(negedge clk);
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    step(1, 0, a, d, 4'hF);
  endtask

  task automatic bus_rd(input logic [31:0] a);
    step(0, 1, a, 32'd0, 4'hF);
  endtask

  task automatic idle();
    step(0, 0, 32'd0, 32'd0, 4'h0);
  endtask

  task automatic do_reset();
    rst = 1; sys_wen = 0; sys_ren = 0; sys_addr = 0; sys_wdata = 0; sys_sel = 0; str_rdy = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    int op;
    rdy = 0;
    do_reset();

    // reset state
    bus_rd(32'h4);
    chk("rst_status", sys_rdata, 32'h0001_0000);
    chk("rst_ack", {31'd0, sys_ack}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd1);
    chk("rst_vld", {31'd0, str_vld}, 32'd0);

    // basic streaming and threshold
    bus_wr(32'hC, 32'd1);
    bus_wr(32'h8, 32'd2);
    for (int i = 0; i < 4; i++) bus_wr(32'h0, 32'hA0 + i);
    chk("head_a0", str_dat, 32'hA0);
    bus_rd(32'h4);
    chk("count4", sys_rdata, 32'h0000_0004);
    chk("irq_lo", {31'd0, irq}, 32'd0);
    rdy = 1;
    idle(); idle();
    rdy = 0;
    chk("head_a2", str_dat, 32'hA2);
    idle();
    chk("irq_hi", {31'd0, irq}, 32'd1);
    bus_rd(32'h4);
    chk("count2", sys_rdata, 32'h0000_0002);

    // overflow with stream disabled
    bus_wr(32'hC, 32'd2);
    for (int i = 0; i < 17; i++) bus_wr(32'h0, i);
    bus_rd(32'h4);
    chk("full_ovf", sys_rdata, 32'h0006_0010);
    bus_wr(32'h4, 32'h0004_0000);
    bus_rd(32'h4);
    chk("ovf_clr", sys_rdata, 32'h0002_0010);

    // push concurrent with pop while full, then drain across the pointer wrap
    rdy = 1;
    bus_wr(32'hC, 32'd1);
    bus_wr(32'h0, 32'h100);
    rdy = 0;
    bus_rd(32'h4);
    chk("full_pushpop", sys_rdata, 32'h0002_0010);
    rdy = 1;
    for (int i = 0; i < 16; i++) idle();
    rdy = 0;
    bus_rd(32'h4);
    chk("drained", sys_rdata, 32'h0001_0000);

    // error responses
    bus_rd(32'h0);
    chk("err_rd_data", {31'd0, sys_err}, 32'd1);
    bus_wr(32'h13, 32'h55);
    chk("err_mirror", {31'd0, sys_err}, 32'd1);
    step(1, 0, 32'h0, 32'h77, 4'h3);
    chk("err_sel", {31'd0, sys_err}, 32'd1);
    step(1, 1, 32'h4, 32'h0004_0000, 4'hF);
    chk("err_wr_rd", {31'd0, sys_err}, 32'd1);
    bus_rd(32'h4);
    chk("err_nopush", sys_rdata, 32'h0001_0000);

    // flush with words queued
    for (int i = 0; i < 5; i++) bus_wr(32'h0, 32'hB0 + i);
    chk("pre_flush_vld", {31'd0, str_vld}, 32'd1);
    bus_wr(32'hC, 32'd3);
    chk("flush_vld", {31'd0, str_vld}, 32'd0);
    bus_rd(32'h4);
    chk("flush_status", sys_rdata, 32'h0001_0000);

    // reset in the ack cycle drops the response
    sys_ren = 1; sys_addr = 32'h4; sys_sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    sys_ren = 0; rst = 1;
    #1 chk("rst_drop_ack", {31'd0, sys_ack}, 32'd0);
    @(posedge clk);
    #1 chk("rst_after_ack", {31'd0, sys_ack}, 32'd0);
    chk("rst_after_vld", {31'd0, str_vld}, 32'd0);
    @(negedge clk);
    rst = 0;
    model_reset();

    // random traffic
    for (int n = 0; n < 1600; n++) begin
      rdy = (n < 800) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 99);
      a  = $urandom() & 32'hFFFF_FFF0;
      d  = $urandom();
      s  = 4'hF;
      if (op < 35) begin
        if ($urandom_range(0, 9) == 0) s = 4'($urandom_range(0, 15));
        step(1, 0, a, d, s);
      end else if (op < 45) bus_rd(a | 32'h4);
      else if (op < 50) bus_wr(a | 32'h4, d);
      else if (op < 58) step(1, 0, a | 32'h8, d, 4'($urandom_range(0, 15)));
      else if (op < 62) bus_rd(a | 32'h8);
      else if (op < 70) bus_wr(a | 32'hC, {30'd0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)});
      else if (op < 73) bus_rd(a | 32'hC);
      else if (op < 77) step($urandom_range(0, 1) == 1, 0, a | 32'($urandom_range(0, 15)), d, 4'hF);
      else if (op < 79) step(1, 1, a | 32'($urandom_range(0, 15)), d, 4'hF);
      else if (op < 82) bus_rd(a);
      else idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
